rsa_decoder: RTL and testbench
==============================

Name: rsa_decoder

Overview:
- Computes the RSA decryption m = c^d mod n for one n_bit-wide ciphertext word per operation.
- Inverse of the team's rsa_encoder. It uses the same modulus and Montgomery constants, and takes the private exponent d as a parameter.
- Architecture: left-to-right square-and-multiply over a sequential radix-2 Montgomery multiplier.
- Sits after the channel or link, and is fed ciphertext words produced by rsa_encoder.

Parameters:
- n, 7'd79: RSA modulus; must be odd and < 2^n_bit.
- n_bit, 7: width of modulus and data words.
- d, 6'd47: private exponent (5·47 ≡ 1 mod 78, matching encoder e=5).
- d_bit, 6: bit width of d; d[d_bit-1] must be 1.
- Rmodn, 7'd49: R mod n, with R = 2^n_bit.
- R2modn, 7'd31: R^2 mod n.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; an operation is accepted on its rising edge only.
- data_in  input  n_bit  ciphertext c; any value 0..2^n_bit-1.
- data_out  output  n_bit  plaintext m, always < n.
- done  output  1  result valid; held high until the next accepted start.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; data_out=0; done=0; busy=0; start edge-detect register cleared. Reset applies in any state and aborts an operation in progress with no result.
- Start detection: start_q registers start. accept = start & ~start_q & (state==IDLE || state==DONE).
  - On accept: capture data_in, set done=0, set busy=1.
  - Rising edges while busy are ignored.
  - A level held high never retriggers.
- Montgomery multiply MM(a,b) = a·b·R^-1 mod n, with a < 2^n_bit and b < n.
  - n_bit iteration cycles, each: t = (t + a_i·b); if t odd then t += n; t >>= 1.
  - The t register is n_bit+2 bits wide.
  - One correction cycle follows: if t ≥ n then t -= n.
  - MM therefore takes exactly n_bit+1 cycles and always returns a value < n.
- FSM states: IDLE → TO_MONT → SQR ↔ MUL → FROM_MONT → DONE.
  - TO_MONT: cm = MM(c, R2modn). x is initialised to Rmodn. Bit index i = d_bit-1.
  - SQR: x = MM(x, x). If d[i]=1 go to MUL; otherwise decrement i, and go to FROM_MONT if i was 0.
  - MUL: x = MM(x, cm). Then decrement i and return to SQR, or go to FROM_MONT if i was 0.
  - FROM_MONT: data_out = MM(x, 1).
  - DONE: done=1 and busy=0. Outputs are held stable; the FSM stays in DONE until accept.
- Latency: the accept edge plus (2 + d_bit + popcount(d))·(n_bit+1) cycles until done rises.
  - Defaults: 1 + 13·8 = 105 cycles.
- Boundary behaviour:
  - c ≥ n gives (c mod n)^d mod n.
  - c=0 gives 0.
  - data_in changes after accept have no effect.
  - data_out changes only when FROM_MONT completes or on reset.

Test Plan:
- Reset: rst=1 for 2 cycles mid-operation, then rst=0 → data_out=0, done=0, busy=0. A fresh start then completes normally.
- Basic decrypt: data_in=26 (encoder output for 20), start 0→1 → done rises exactly 105 cycles after accept, with data_out=20. Encoder/decoder loopback of 20 also yields 20.
- Edge values: c=0 → 0; c=1 → 1; c=78 → 78, since (-1)^47 ≡ -1.
- Unreduced input: c=105 (26+79) → 20. c=127 → (48^47 mod 79), checked against the bench's software model.
- Handshake: start held high after done → no second run, and done stays 1. Toggle start and change data_in during busy → ignored; the result equals the originally captured c.
- Sweep: all c in 0..127 back-to-back (drop start, raise start after each done) → every data_out equals the model's c^47 mod 79. done deasserts the cycle after each accept.

Source files
------------

// File: rtl/rsa_decoder.sv
// rsa_decoder: RSA decryption m = c^d mod n using left-to-right
// square-and-multiply over a bit-serial radix-2 Montgomery multiplier.
// One ciphertext word per operation, started on a rising edge of start.
module rsa_decoder #(
  parameter int unsigned       n_bit  = 7,
  parameter logic [n_bit-1:0]  n      = 7'd79,
  parameter int unsigned       d_bit  = 6,
  parameter logic [d_bit-1:0]  d      = 6'd47,
  parameter logic [n_bit-1:0]  Rmodn  = 7'd49,
  parameter logic [n_bit-1:0]  R2modn = 7'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n_bit-1:0] data_in,
  output logic [n_bit-1:0] data_out,
  output logic             done,
  output logic             busy
);

  localparam int unsigned TW = n_bit + 2;
  localparam int unsigned CW = $clog2(n_bit + 1);
  localparam int unsigned IW = (d_bit > 1) ? $clog2(d_bit) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TO_MONT,
    S_SQR,
    S_MUL,
    S_FROM_MONT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [n_bit-1:0] c_q, c_d;
  logic [n_bit-1:0] cm_q, cm_d;
  logic [n_bit-1:0] x_q, x_d;
  logic [TW-1:0]    t_q, t_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [n_bit-1:0] data_out_q, data_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [n_bit-1:0] mm_a, mm_b;
  logic             a_bit;
  logic [TW-1:0]    t_add, t_odd, t_iter;
  logic [n_bit-1:0] mm_res;
  logic             mm_last;
  logic             d_cur;
  logic             accept;

  // Montgomery datapath: operand select, one iteration step, final correction
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    unique case (state_q)
      S_TO_MONT:   begin mm_a = c_q; mm_b = R2modn;          end
      S_SQR:       begin mm_a = x_q; mm_b = x_q;             end
      S_MUL:       begin mm_a = x_q; mm_b = cm_q;            end
      S_FROM_MONT: begin mm_a = x_q; mm_b = n_bit'(1);       end
      default:     begin mm_a = '0;  mm_b = '0;              end
    endcase
    a_bit   = |(mm_a & (n_bit'(1) << cnt_q));
    t_add   = t_q + (a_bit ? {2'b00, mm_b} : '0);
    t_odd   = t_add + (t_add[0] ? {2'b00, n} : '0);
    t_iter  = t_odd >> 1;
    mm_res  = n_bit'((t_q >= {2'b00, n}) ? (t_q - {2'b00, n}) : t_q);
    mm_last = (cnt_q == CW'(n_bit));
    d_cur   = |(d & (d_bit'(1) << idx_q));
  end

  // Sequencing of square-and-multiply and the start handshake
  always_comb begin
    state_d    = state_q;
    start_d    = start;
    c_d        = c_q;
    cm_d       = cm_q;
    x_d        = x_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    done_d     = done_q;
    busy_d     = busy_q;
    accept     = start & ~start_q & ((state_q == S_IDLE) || (state_q == S_DONE));

    if ((state_q == S_TO_MONT) || (state_q == S_SQR) ||
        (state_q == S_MUL) || (state_q == S_FROM_MONT)) begin
      if (mm_last) begin
        t_d   = '0;
        cnt_d = '0;
      end else begin
        t_d   = t_iter;
        cnt_d = cnt_q + CW'(1);
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          c_d     = data_in;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          t_d     = '0;
          cnt_d   = '0;
          state_d = S_TO_MONT;
        end
      end
      S_TO_MONT: begin
        if (mm_last) begin
          cm_d    = mm_res;
          x_d     = Rmodn;
          idx_d   = IW'(d_bit - 1);
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        if (mm_last) begin
          x_d = mm_res;
          if (d_cur) begin
            state_d = S_MUL;
          end else if (idx_q == '0) begin
            state_d = S_FROM_MONT;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      S_MUL: begin
        if (mm_last) begin
          x_d = mm_res;
          if (idx_q == '0) begin
            state_d = S_FROM_MONT;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = S_SQR;
          end
        end
      end
      S_FROM_MONT: begin
        if (mm_last) begin
          data_out_d = mm_res;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      c_q        <= '0;
      cm_q       <= '0;
      x_q        <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      c_q        <= c_d;
      cm_q       <= cm_d;
      x_q        <= x_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rsa_decoder.sv
// tb_rsa_decoder: scoreboard bench for rsa_decoder. Stimulus pushes the
// expected plaintext and accept cycle; a monitor pops on each rising done.
module tb_rsa_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] data_in;
  logic [6:0] data_out;
  logic       done;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int exp_q[$];
  int acc_q[$];

  rsa_decoder #(
    .n_bit (7),
    .n     (7'd79),
    .d_bit (6),
    .d     (6'd47),
    .Rmodn (7'd49),
    .R2modn(7'd31)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .data_out(data_out),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: repeated modular multiplication, nothing Montgomery-specific
  function automatic int modexp(input int b, input int e, input int m);
    int r;
    int bb;
    r  = 1;
    bb = b % m;
    for (int i = 0; i < e; i++) r = (r * bb) % m;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: result and latency on each done rise; data_out must not move otherwise
  logic       prev_done = 1'b0;
  logic [6:0] prev_out  = '0;
  always @(negedge clk) begin
    int e;
    int a;
    if (rst) begin
      prev_done = done;
      prev_out  = data_out;
    end else begin
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1, expected no pending operation");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("data_out", int'(data_out), e);
          // accept edge counted as cycle 1
          check("latency", cyc - a + 1, 105);
        end
      end else if (data_out !== prev_out) begin
        vectors++;
        miscompares++;
        $display("FAIL data_out_stable: got %0d, expected %0d", data_out, prev_out);
      end
      prev_done = done;
      prev_out  = data_out;
    end
  end

  task automatic issue(input logic [6:0] c, input int expv, input bit track);
    @(negedge clk);
    start   = 1'b0;
    data_in = c;
    @(negedge clk);
    start = 1'b1;
    if (track) begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    check("done_low_after_accept", int'(done), 0);
    check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int enc;
    int c;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_data_out", int'(data_out), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;

    // basic decrypt and encoder loopback
    issue(7'd26, 20, 1'b1);
    wait_done();
    enc = modexp(20, 5, 79);
    issue(7'(enc), 20, 1'b1);
    wait_done();

    // edge and unreduced inputs
    issue(7'd0, 0, 1'b1);    wait_done();
    issue(7'd1, 1, 1'b1);    wait_done();
    issue(7'd78, 78, 1'b1);  wait_done();
    issue(7'd105, 20, 1'b1); wait_done();
    issue(7'd127, modexp(48, 47, 79), 1'b1); wait_done();

    // start held high after done: no rerun
    repeat (20) @(negedge clk);
    check("hold_done", int'(done), 1);
    check("hold_busy", int'(busy), 0);

    // start toggles and data_in changes while busy are ignored
    issue(7'd50, modexp(50, 47, 79), 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start   = ~start;
      data_in = 7'($urandom_range(0, 127));
    end
    start = 1'b0;
    wait_done();

    // reset in the middle of an operation aborts it without a result
    issue(7'd33, 0, 1'b0);
    repeat (30) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midop_reset_data_out", int'(data_out), 0);
    check("midop_reset_done", int'(done), 0);
    check("midop_reset_busy", int'(busy), 0);
    rst = 1'b0;
    issue(7'd26, 20, 1'b1);
    wait_done();

    // full sweep of every input word
    for (int v = 0; v < 128; v++) begin
      issue(7'(v), modexp(v, 47, 79), 1'b1);
      wait_done();
    end

    // random words
    for (int r = 0; r < 16; r++) begin
      c = int'($urandom_range(0, 127));
      issue(7'(c), modexp(c, 47, 79), 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
